phase_calc_seq: RTL and testbench

Sequential, parametrised per-transducer phase calculator for the levitation array. It replaces the floating-point pipeline with an all-integer datapath built from three parts: a runtime-loadable transducer coordinate and calibration table, an iterative integer square root, and a power-of-two phase wrap. For each channel it produces a phase count and an enable flag. It sits between the focal-point sequencer (which drives `start`/`cycleStart`) and the per-channel PWM phase generators.

---
 rtl/phase_calc_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_phase_calc_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/phase_calc_seq.sv
// Per-transducer phase calculator: table lookup, squared distance, iterative
// integer square root and power-of-two phase wrap, one channel at a time.

module phase_calc_seq_ch #(
  parameter int PHASE_BIT_SIZE = 9
) (
  input  logic                      clk,
  input  logic                      nReset,
  input  logic                      we,
  input  logic [PHASE_BIT_SIZE-1:0] nxt_phase,
  input  logic                      nxt_en,
  output logic [PHASE_BIT_SIZE-1:0] phase,
  output logic                      en
);
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      phase <= '0;
      en    <= 1'b0;
    end else if (we) begin
      phase <= nxt_phase;
      en    <= nxt_en;
    end
  end
endmodule

module phase_calc_seq #(
  parameter int NUM_CHANNELS   = 50,
  parameter int POS_BIT_SIZE   = 12,
  parameter int PHASE_BIT_SIZE = 9,
  parameter int K_NUM          = 6114,
  parameter int K_SHIFT        = 10
) (
  input  logic                                         clk,
  input  logic                                         nReset,
  input  logic                                         cfgWe,
  input  logic [$clog2(NUM_CHANNELS)-1:0]              cfgAddr,
  input  logic [POS_BIT_SIZE-1:0]                      cfgX,
  input  logic [POS_BIT_SIZE-1:0]                      cfgZ,
  input  logic [PHASE_BIT_SIZE-1:0]                    cfgOffset,
  input  logic [POS_BIT_SIZE-1:0]                      x,
  input  logic [POS_BIT_SIZE-1:0]                      y,
  input  logic [POS_BIT_SIZE-1:0]                      z,
  input  logic [POS_BIT_SIZE-1:0]                      halfHeight,
  input  logic [2*POS_BIT_SIZE+3:0]                    xzRadiusSquared,
  input  logic                                         top,
  input  logic                                         mirrorX,
  input  logic                                         invert,
  input  logic                                         start,
  input  logic                                         cycleStart,
  output logic                                         busy,
  output logic                                         done,
  output logic [NUM_CHANNELS-1:0][PHASE_BIT_SIZE-1:0]  phase,
  output logic [NUM_CHANNELS-1:0]                      phaseEnabled
);
  localparam int P    = POS_BIT_SIZE;
  localparam int PH   = PHASE_BIT_SIZE;
  localparam int DW   = P + 1;
  localparam int SW   = 2*P + 4;
  localparam int RW   = P + 2;
  localparam int RMW  = RW + 6;
  localparam int AW   = $clog2(NUM_CHANNELS);
  localparam int CNTW = $clog2(RW);
  localparam int PW   = RW + 32;
  localparam logic [PH-1:0] HALF = PH'(2**(PH-1));

  typedef enum logic [2:0] {S_IDLE, S_DIFF, S_SQRT, S_SCALE, S_WRITE, S_FIN} state_t;

  typedef struct packed {
    logic [P-1:0]  x;
    logic [P-1:0]  y;
    logic [P-1:0]  z;
    logic [P-1:0]  hh;
    logic [SW-1:0] r2;
    logic          top;
    logic          mirror;
    logic          invert;
  } focal_t;

  state_t state, state_nxt;
  focal_t f;

  logic [AW-1:0]         ch;
  logic [CNTW-1:0]       cnt;
  logic [SW-1:0]         sum_xz, rad;
  logic signed [RMW-1:0] rem;
  logic [RW-1:0]         root;
  logic [PH-1:0]         p;

  logic accept, diff_en, sqrt_en, scale_en, wr_en, fin, last_ch, sqrt_last, addr_ok;

  // Coordinate/calibration table: no reset so it maps onto RAM.
  logic [P-1:0]  tbl_x   [NUM_CHANNELS];
  logic [P-1:0]  tbl_z   [NUM_CHANNELS];
  logic [PH-1:0] tbl_off [NUM_CHANNELS];

  assign addr_ok = {1'b0, cfgAddr} < (AW+1)'(NUM_CHANNELS);

  always_ff @(posedge clk) begin
    if (cfgWe && state == S_IDLE && addr_ok) begin
      tbl_x[cfgAddr]   <= cfgX;
      tbl_z[cfgAddr]   <= cfgZ;
      tbl_off[cfgAddr] <= cfgOffset;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= S_IDLE;
    else         state <= state_nxt;
  end

  assign last_ch   = ch == AW'(NUM_CHANNELS-1);
  assign sqrt_last = cnt == CNTW'(RW-1);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DIFF;
      S_DIFF:  state_nxt = S_SQRT;
      S_SQRT:  if (sqrt_last) state_nxt = S_SCALE;
      S_SCALE: state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_ch ? S_FIN : S_DIFF;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    diff_en  = 1'b0;
    sqrt_en  = 1'b0;
    scale_en = 1'b0;
    wr_en    = 1'b0;
    fin      = 1'b0;
    case (state)
      S_IDLE:  accept   = start;
      S_DIFF:  diff_en  = 1'b1;
      S_SQRT:  sqrt_en  = 1'b1;
      S_SCALE: scale_en = 1'b1;
      S_WRITE: wr_en    = 1'b1;
      S_FIN:   fin      = 1'b1;
      default: ;
    endcase
  end

  // Squared distance from the transducer to the latched focal point.
  logic signed [DW-1:0]   tx, tz, hh, dx, dy, dz;
  logic signed [2*DW-1:0] dx2, dy2, dz2;
  logic [SW-1:0]          sum_xz_c, sum_c;

  always_comb begin
    tx       = {tbl_x[ch][P-1], tbl_x[ch]};
    tz       = {tbl_z[ch][P-1], tbl_z[ch]};
    hh       = {f.hh[P-1], f.hh};
    dx       = {f.x[P-1], f.x} - (f.mirror ? -tx : tx);
    dy       = {f.y[P-1], f.y} - (f.top ? -hh : hh);
    dz       = {f.z[P-1], f.z} - tz;
    dx2      = dx * dx;
    dy2      = dy * dy;
    dz2      = dz * dz;
    sum_xz_c = SW'($unsigned(dx2)) + SW'($unsigned(dz2));
    sum_c    = sum_xz_c + SW'($unsigned(dy2));
  end

  // Non-restoring root step: the sign of the new remainder is the next bit.
  logic signed [RMW-1:0] rem_sh, rem_n;
  logic [RW-1:0]         root_n;

  always_comb begin
    rem_sh = (rem <<< 2) | RMW'(rad[SW-1:SW-2]);
    if (rem[RMW-1]) rem_n = rem_sh + RMW'({root, 2'b11});
    else            rem_n = rem_sh - RMW'({root, 2'b01});
    root_n = {root[RW-2:0], ~rem_n[RMW-1]};
  end

  logic [PW-1:0] prod;
  logic [PH-1:0] p_c;
  logic          en_c;

  always_comb begin
    prod = PW'(root) * PW'(K_NUM);
    p_c  = tbl_off[ch] - PH'(prod >> K_SHIFT) + (f.invert ? HALF : '0);
    en_c = sum_xz < f.r2;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      f      <= '0;
      ch     <= '0;
      cnt    <= '0;
      sum_xz <= '0;
      rad    <= '0;
      rem    <= '0;
      root   <= '0;
      p      <= '0;
    end else begin
      if (accept) begin
        f  <= {x, y, z, halfHeight, xzRadiusSquared, top, mirrorX, invert};
        ch <= '0;
      end
      if (diff_en) begin
        sum_xz <= sum_xz_c;
        rad    <= sum_c;
        rem    <= '0;
        root   <= '0;
        cnt    <= '0;
      end
      if (sqrt_en) begin
        rad  <= rad << 2;
        rem  <= rem_n;
        root <= root_n;
        cnt  <= cnt + 1'b1;
      end
      if (scale_en) p <= p_c;
      if (wr_en && !last_ch) ch <= ch + 1'b1;
    end
  end

  assign busy = state != S_IDLE;

  // cycleStart outranks the completion pulse.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)         done <= 1'b0;
    else if (cycleStart) done <= 1'b0;
    else if (fin)        done <= 1'b1;
    else if (accept)     done <= 1'b0;
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    phase_calc_seq_ch #(.PHASE_BIT_SIZE(PH)) u_ch (
      .clk       (clk),
      .nReset    (nReset),
      .we        (wr_en && ch == AW'(g)),
      .nxt_phase (p),
      .nxt_en    (en_c),
      .phase     (phase[g]),
      .en        (phaseEnabled[g])
    );
  end
endmodule

// File: tb/tb_phase_calc_seq.sv
// Directed and randomized checks of phase_calc_seq against an arithmetic model.

module tb_phase_calc_seq;
  localparam int NCH = 4;
  localparam int P   = 12;
  localparam int PH  = 9;
  localparam int SW  = 2*P + 4;
  localparam int KN  = 6114;
  localparam int KS  = 10;
  localparam int C   = P + 2 + 3;
  localparam int LAT = NCH*C + 1;

  logic                        clk = 1'b0;
  logic                        nReset = 1'b0;
  logic                        cfgWe = 1'b0;
  logic [1:0]                  cfgAddr = '0;
  logic [P-1:0]                cfgX = '0, cfgZ = '0;
  logic [PH-1:0]               cfgOffset = '0;
  logic [P-1:0]                x = '0, y = '0, z = '0, halfHeight = '0;
  logic [SW-1:0]               xzRadiusSquared = '0;
  logic                        top = 1'b0, mirrorX = 1'b0, invert = 1'b0;
  logic                        start = 1'b0, cycleStart = 1'b0;
  logic                        busy, done;
  logic [NCH-1:0][PH-1:0]      phase;
  logic [NCH-1:0]              phaseEnabled;

  phase_calc_seq #(.NUM_CHANNELS(NCH)) dut (
    .clk(clk), .nReset(nReset), .cfgWe(cfgWe), .cfgAddr(cfgAddr),
    .cfgX(cfgX), .cfgZ(cfgZ), .cfgOffset(cfgOffset),
    .x(x), .y(y), .z(z), .halfHeight(halfHeight),
    .xzRadiusSquared(xzRadiusSquared), .top(top), .mirrorX(mirrorX),
    .invert(invert), .start(start), .cycleStart(cycleStart),
    .busy(busy), .done(done), .phase(phase), .phaseEnabled(phaseEnabled)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int     tx [NCH];
  int     tz [NCH];
  int     off[NCH];
  int     fx, fy, fz, fhh;
  bit     ftop, fmx, finv;
  longint fr2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int rs();
    return int'($urandom_range(0, 4095)) - 2048;
  endfunction

  // Reference: geometric distance, floor square root, modular phase.
  function automatic void model(input int c, output int ph, output bit en);
    longint dx, dy, dz, sxz, s, r, sc, v;
    dx  = longint'(fx) - (fmx ? -longint'(tx[c]) : longint'(tx[c]));
    dy  = longint'(fy) - (ftop ? -longint'(fhh) : longint'(fhh));
    dz  = longint'(fz) - longint'(tz[c]);
    sxz = dx*dx + dz*dz;
    s   = sxz + dy*dy;
    r   = longint'($sqrt(real'(s)));
    while (r*r > s) r--;
    while ((r+1)*(r+1) <= s) r++;
    sc  = (r * KN) / (longint'(1) << KS);
    v   = longint'(off[c]) - sc + (finv ? 256 : 0);
    ph  = int'(((v % 512) + 512) % 512);
    en  = sxz < fr2;
  endfunction

  task automatic load(input int c, input int xv, input int zv, input int ov);
    @(negedge clk);
    cfgWe = 1'b1; cfgAddr = 2'(c); cfgX = 12'(xv); cfgZ = 12'(zv); cfgOffset = 9'(ov);
    @(posedge clk); #1;
    cfgWe = 1'b0;
    tx[c] = xv; tz[c] = zv; off[c] = ov;
  endtask

  task automatic set_focal(input int xv, input int yv, input int zv, input int hv,
                           input bit tp, input bit mx, input bit iv, input longint r2);
    fx = xv; fy = yv; fz = zv; fhh = hv; ftop = tp; fmx = mx; finv = iv; fr2 = r2;
    x = 12'(xv); y = 12'(yv); z = 12'(zv); halfHeight = 12'(hv);
    top = tp; mirrorX = mx; invert = iv; xzRadiusSquared = 28'(r2);
  endtask

  task automatic scramble();
    x = 12'($urandom); y = 12'($urandom); z = 12'($urandom); halfHeight = 12'($urandom);
    xzRadiusSquared = 28'($urandom);
    top = 1'($urandom); mirrorX = 1'($urandom); invert = 1'($urandom);
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // One full computation; hs pokes start/cfgWe mid-run, cs asserts cycleStart on the done edge.
  task automatic run(input bit hs, input bit cs);
    int            exp_ph[NCH];
    bit            exp_en[NCH];
    logic [PH-1:0] prev0, prev1;
    for (int i = 0; i < NCH; i++) model(i, exp_ph[i], exp_en[i]);
    prev0 = phase[0];
    prev1 = phase[1];
    launch();
    chk("busy_rise", 64'(busy), 64'(1));
    chk("done_clr_on_start", 64'(done), 64'(0));
    scramble();
    for (int n = 1; n <= LAT; n++) begin
      @(negedge clk);
      start      = hs && n == 10;
      cfgWe      = hs && n == 10;
      if (hs && n == 10) begin
        cfgAddr = 2'd3; cfgX = 12'($urandom); cfgZ = 12'($urandom); cfgOffset = 9'($urandom);
      end
      cycleStart = cs && n == LAT;
      @(posedge clk); #1;
      if (n == C-1) chk("ch0_before_write", 64'(phase[0]), 64'(prev0));
      if (n == C) begin
        chk("ch0_write_edge", 64'(phase[0]), 64'(exp_ph[0]));
        chk("ch1_untouched", 64'(phase[1]), 64'(prev1));
      end
      if (n == LAT-1) begin
        chk("busy_before_done", 64'(busy), 64'(1));
        chk("done_before_edge", 64'(done), 64'(0));
      end
    end
    start = 1'b0; cfgWe = 1'b0; cycleStart = 1'b0;
    chk("done_at_latency", 64'(done), 64'(!cs));
    chk("busy_fall", 64'(busy), 64'(0));
    for (int i = 0; i < NCH; i++) begin
      chk($sformatf("phase[%0d]", i), 64'(phase[i]), 64'(exp_ph[i]));
      chk($sformatf("enable[%0d]", i), 64'(phaseEnabled[i]), 64'(exp_en[i]));
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_phase", 64'(phase), 64'(0));
    chk("rst_enable", 64'(phaseEnabled), 64'(0));
    @(negedge clk);
    nReset = 1'b1;

    // Single-channel math: sum 90000, root 300
    load(0, 0, 0, 0);
    for (int i = 1; i < NCH; i++) load(i, rs(), rs(), int'($urandom_range(0, 511)));
    set_focal(0, 0, 0, 300, 1'b0, 1'b0, 1'b0, longint'($urandom_range(0, 1 << 22)));
    run(1'b0, 1'b0);
    chk("ch0_r300", 64'(phase[0]), 64'(257));
    set_focal(0, 0, 0, 300, 1'b0, 1'b0, 1'b1, longint'($urandom_range(0, 1 << 22)));
    run(1'b0, 1'b0);
    chk("ch0_r300_inv", 64'(phase[0]), 64'(1));

    // Mirror cancels the offset; then a unit distance
    begin
      int o;
      o = int'($urandom_range(0, 511));
      load(0, 50, 0, o);
      set_focal(-50, 0, 0, 0, 1'b0, 1'b1, 1'b0, 64'd1000);
      run(1'b0, 1'b0);
      chk("mirror_zero_dist", 64'(phase[0]), 64'(o));
    end
    load(0, 50, 0, 511);
    set_focal(-50, 1, 0, 0, 1'b0, 1'b1, 1'b0, 64'd1000);
    run(1'b0, 1'b0);

    // Enable boundary: sumXZ = 25
    load(1, 0, 0, int'($urandom_range(0, 511)));
    set_focal(3, rs(), 4, rs(), 1'($urandom), 1'b0, 1'($urandom), 64'd25);
    run(1'b0, 1'b0);
    chk("enable_eq_radius", 64'(phaseEnabled[1]), 64'(0));
    set_focal(3, rs(), 4, rs(), 1'($urandom), 1'b0, 1'($urandom), 64'd26);
    run(1'b0, 1'b0);
    chk("enable_lt_radius", 64'(phaseEnabled[1]), 64'(1));

    // Busy-time start/cfgWe are dropped; cycleStart on the done edge wins
    set_focal(rs(), rs(), rs(), rs(), 1'($urandom), 1'($urandom), 1'($urandom),
              longint'($urandom_range(0, 1 << 23)));
    run(1'b1, 1'b1);
    set_focal(rs(), rs(), rs(), rs(), 1'($urandom), 1'($urandom), 1'($urandom),
              longint'($urandom_range(0, 1 << 23)));
    run(1'b0, 1'b0);
    @(negedge clk);
    cycleStart = 1'b1;
    @(posedge clk); #1;
    cycleStart = 1'b0;
    chk("cyclestart_clears", 64'(done), 64'(0));

    // Reset during channel 3 square root
    set_focal(rs(), rs(), rs(), rs(), 1'b0, 1'b0, 1'b0, 64'd1000000);
    launch();
    repeat (55) begin @(posedge clk); #1; end
    nReset = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    chk("midrst_phase", 64'(phase), 64'(0));
    chk("midrst_enable", 64'(phaseEnabled), 64'(0));
    @(negedge clk);
    nReset = 1'b1;
    set_focal(rs(), rs(), rs(), rs(), 1'($urandom), 1'($urandom), 1'($urandom),
              longint'($urandom_range(0, 1 << 23)));
    run(1'b0, 1'b0);

    // Extreme geometry: largest representable distances
    for (int i = 0; i < NCH; i++) load(i, -2048, -2048, int'($urandom_range(0, 511)));
    set_focal(2047, 2047, 2047, 2047, 1'b1, 1'b0, 1'b1, 64'd40000000);
    run(1'b0, 1'b0);

    // Randomized tables and focal points
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NCH; i++) load(i, rs(), rs(), int'($urandom_range(0, 511)));
      set_focal(rs(), rs(), rs(), rs(), 1'($urandom), 1'($urandom), 1'($urandom),
                longint'($urandom_range(0, 1 << 24)));
      run(1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
